// File: rtl/imm_ext_if.sv
// Capture/operand bus between the decode stage and the immediate-extension register.
interface imm_ext_if #(
  parameter int unsigned JIDX_W = 26,
  parameter int unsigned OUT_W  = 32
);
  localparam int unsigned PC_W = OUT_W - JIDX_W - 2;

  logic              ld;
  logic              clr;
  logic [2:0]        ext_op;
  logic [JIDX_W-1:0] instr_field;
  logic [PC_W-1:0]   pc_hi;
  logic [OUT_W-1:0]  imm_out;
  logic              imm_vld;
  logic              op_err;

  // Decode side: drives capture controls, receives the held operand.
  modport master (
    output ld, clr, ext_op, instr_field, pc_hi,
    input  imm_out, imm_vld, op_err
  );

  // Extension register side.
  modport slave (
    input  ld, clr, ext_op, instr_field, pc_hi,
    output imm_out, imm_vld, op_err
  );
endinterface

// File: rtl/imm_ext_reg.sv
// Registered immediate-extension unit: forms zero/sign/LUI/branch/jump operands
// on a capture strobe and holds them, with a sticky illegal-mode error state.
module imm_ext_reg #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIDX_W = 26,
  parameter int unsigned OUT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  imm_ext_if.slave    bus
);
  localparam int unsigned PC_W  = OUT_W - JIDX_W - 2;
  localparam int unsigned EXT_W = OUT_W - IMM_W;

  localparam logic [2:0] OP_ZERO   = 3'b000;
  localparam logic [2:0] OP_SIGN   = 3'b001;
  localparam logic [2:0] OP_LUI    = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_JUMP   = 3'b100;

  // Reject parameter sets for which the jump/LUI formats cannot be built.
  if (!((OUT_W > JIDX_W + 2) && (JIDX_W >= IMM_W) && (OUT_W >= 2 * IMM_W))) begin : g_param_err
    $error("imm_ext_reg: illegal IMM_W/JIDX_W/OUT_W combination");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    VALID = 2'b01,
    ERROR = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] imm_q, imm_d;
  logic             imm_vld_q, imm_vld_d;
  logic             op_err_q, op_err_d;

  logic [IMM_W-1:0] imm;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] formed;
  logic             op_legal;

  // Operand formation for every mode; legality decided alongside.
  always_comb begin
    imm      = bus.instr_field[IMM_W-1:0];
    sext     = {{EXT_W{imm[IMM_W-1]}}, imm};
    formed   = '0;
    op_legal = 1'b1;
    case (bus.ext_op)
      OP_ZERO:   formed = {{EXT_W{1'b0}}, imm};
      OP_SIGN:   formed = sext;
      OP_LUI:    formed = {imm, {EXT_W{1'b0}}};
      OP_BRANCH: formed = {sext[OUT_W-3:0], 2'b00};
      OP_JUMP:   formed = {bus.pc_hi, bus.instr_field, 2'b00};
      default:   op_legal = 1'b0;
    endcase
  end

  // Next-state: clr beats ld, ERROR is sticky until clr/rst, idle holds.
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    if (bus.clr) begin
      state_d = EMPTY;
      imm_d   = '0;
    end else if (bus.ld && (state_q != ERROR)) begin
      if (op_legal) begin
        state_d = VALID;
        imm_d   = formed;
      end else begin
        state_d = ERROR;
        imm_d   = '0;
      end
    end
    imm_vld_d = (state_d == VALID);
    op_err_d  = (state_d == ERROR);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      imm_q     <= '0;
      imm_vld_q <= 1'b0;
      op_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      imm_q     <= imm_d;
      imm_vld_q <= imm_vld_d;
      op_err_q  <= op_err_d;
    end
  end

  assign bus.imm_out = imm_q;
  assign bus.imm_vld = imm_vld_q;
  assign bus.op_err  = op_err_q;
endmodule

// File: doc/imm_ext_reg.md
Name: imm_ext_reg

Overview:
Registered, parametrised immediate-extension unit for the multicycle datapath. Captures the instruction immediate field in the decode cycle and holds the extended operand stable for the following execute and memory cycles. Beyond zero, sign and LUI extension, it adds branch-offset (sign-extend, shift left 2) and jump-target formation, a valid flag, and a sticky illegal-mode error flag.

Parameters:
IMM_W, 16, I-type immediate width (low IMM_W bits of instr_field).
JIDX_W, 26, J-type index width; equals instr_field width.
OUT_W, 32, extended operand width. Must satisfy OUT_W > JIDX_W+2, JIDX_W >= IMM_W and OUT_W >= 2*IMM_W; elaboration error otherwise.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
ld  input  1  capture strobe; samples ext_op, instr_field and pc_hi.
clr  input  1  synchronous clear of held operand and flags.
ext_op  input  3  mode: 000 zero, 001 sign, 010 LUI, 011 branch, 100 jump; 101–111 illegal.
instr_field  input  JIDX_W  instruction bits [JIDX_W-1:0].
pc_hi  input  OUT_W-JIDX_W-2  upper PC bits for jump mode.
imm_out  output  OUT_W  held extended operand.
imm_vld  output  1  imm_out holds a legally formed value.
op_err  output  1  sticky: an illegal ext_op was captured.

Behaviour:
- Reset (async, any time, including mid-hold): imm_out=0, imm_vld=0, op_err=0, FSM=EMPTY. Release is synchronous to clk.
- Let imm = instr_field[IMM_W-1:0].
- Zero: {0, imm}.
- Sign: imm sign-extended to OUT_W.
- LUI: {imm, (OUT_W-IMM_W) zeros}.
- Branch: (sign-extended imm) << 2, truncated to OUT_W.
- Jump: {pc_hi, instr_field, 2'b00}.
- Latency: 1 cycle. Values sampled at the ld edge appear on imm_out after that edge.
- imm_out is stable while ld=0. Changes on ext_op, instr_field or pc_hi without ld have no effect.
- FSM states: EMPTY, VALID, ERROR. Encoding is internal; imm_vld=1 only in VALID, op_err=1 only in ERROR.
- Transitions, any state:
  - clr → EMPTY, with imm_out=0. clr has priority over ld in the same cycle.
  - ld with legal op → VALID, imm_out=formed value.
  - ld with illegal op → ERROR, imm_out=0.
- ERROR is sticky. A later legal ld does not leave ERROR: imm_out stays 0 and imm_vld stays 0 until clr or rst.
- VALID → VALID on back-to-back ld. Each ld overwrites imm_out. No bubble and no hold-off.
- No other state changes occur without ld, clr or rst.
- All arithmetic is unsigned bit concatenation. No overflow detection. Branch-mode top bits shifted out are discarded.

Test Plan:
- rst pulse mid-cycle while in VALID holding 0x12340000 → imm_out=0 and imm_vld=0 immediately (asynchronous); op_err=0.
- ld, op=001, field[15:0]=0x8004 → next cycle imm_out=0xFFFF8004, imm_vld=1. Then op=000, same field → imm_out=0x00008004.
- ld, op=010, imm=0x1234 → 0x12340000. Then ld, op=011, imm=0xFFFF → 0xFFFFFFFC. Back-to-back cycles, both values held correctly.
- ld, op=100, pc_hi=0x4, field=26'h0000010 → imm_out=0x40000040. Inputs then toggled with ld=0 → imm_out unchanged.
- ld, op=101 → op_err=1, imm_vld=0, imm_out=0. Next ld, op=001 → still ERROR, imm_out=0. clr → EMPTY, op_err=0.
- ld and clr asserted together with op=001, imm=0x0001 → EMPTY, imm_out=0, imm_vld=0.
